// File: rtl/dac_frame_receiver.sv
// dac_frame_receiver
//   Receiving end of the DAC serial link. Deserializes MSB-first frames on
//   serialClock while syncDAC is low, keeps the last complete frame in
//   holdData, and transfers it to dacOut/ctrlOut whenever ldac is sampled low
//   (input register / DAC register pair, as in the DAC itself).
//
// Ports
//   serialClock  in   sole clock, all inputs sampled on the rising edge
//   resetN       in   synchronous active-low reset
//   syncDAC      in   active-low frame enable
//   dIn          in   serial data, MSB first
//   ldac         in   active-low load strobe, level-sampled
//   holdData     out  last complete frame
//   dacOut       out  loaded data field (low DATA_BITS of the frame)
//   ctrlOut      out  loaded control field (upper bits of the frame)
//   frameValid   out  one-cycle pulse when a frame completes
//   frameError   out  one-cycle pulse on a short frame or an overrun
//   frameCount   out  completed-frame count, wraps 255 -> 0
module dac_frame_receiver #(
    parameter int FRAME_BITS = 16,
    parameter int DATA_BITS  = 12
) (
    input  logic                             serialClock,
    input  logic                             resetN,
    input  logic                             syncDAC,
    input  logic                             dIn,
    input  logic                             ldac,
    output logic [FRAME_BITS-1:0]            holdData,
    output logic [DATA_BITS-1:0]             dacOut,
    output logic [FRAME_BITS-DATA_BITS-1:0]  ctrlOut,
    output logic                             frameValid,
    output logic                             frameError,
    output logic [7:0]                       frameCount
);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } stateT;

    // bitCnt holds the number of bits already received, so the bit being
    // sampled in SHIFT is the last one when bitCnt equals FRAME_BITS-1.
    localparam logic [4:0] LAST_BIT = 5'(FRAME_BITS - 1);

    stateT                  state, stateNext;
    logic [4:0]             bitCnt, bitCntNext;
    logic [FRAME_BITS-1:0]  shiftReg, shiftNext;
    logic [FRAME_BITS-1:0]  holdNext;
    logic                   overrunSeen, overrunNext;
    logic                   validNext, errorNext;
    logic [7:0]             countNext;

    always_ff @(posedge serialClock) begin
        if (!resetN) begin
            state       <= IDLE;
            bitCnt      <= '0;
            shiftReg    <= '0;
            holdData    <= '0;
            overrunSeen <= 1'b0;
            frameValid  <= 1'b0;
            frameError  <= 1'b0;
            frameCount  <= '0;
        end else begin
            state       <= stateNext;
            bitCnt      <= bitCntNext;
            shiftReg    <= shiftNext;
            holdData    <= holdNext;
            overrunSeen <= overrunNext;
            frameValid  <= validNext;
            frameError  <= errorNext;
            frameCount  <= countNext;
        end
    end

    always_comb begin
        stateNext   = state;
        bitCntNext  = bitCnt;
        shiftNext   = shiftReg;
        holdNext    = holdData;
        overrunNext = overrunSeen;
        validNext   = 1'b0;
        errorNext   = 1'b0;
        countNext   = frameCount;

        case (state)
            IDLE: begin
                if (!syncDAC) begin
                    shiftNext  = {{(FRAME_BITS-1){1'b0}}, dIn};
                    bitCntNext = 5'd1;
                    stateNext  = SHIFT;
                end
            end

            SHIFT: begin
                if (!syncDAC) begin
                    shiftNext  = {shiftReg[FRAME_BITS-2:0], dIn};
                    bitCntNext = bitCnt + 5'd1;
                    if (bitCnt == LAST_BIT) begin
                        holdNext    = {shiftReg[FRAME_BITS-2:0], dIn};
                        validNext   = 1'b1;
                        countNext   = frameCount + 8'd1;
                        overrunNext = 1'b0;
                        stateNext   = DONE;
                    end
                end else begin
                    // Short frame: drop the partial word, holdData untouched.
                    errorNext  = 1'b1;
                    bitCntNext = '0;
                    shiftNext  = '0;
                    stateNext  = IDLE;
                end
            end

            DONE: begin
                if (!syncDAC) begin
                    // Overrun bits are ignored; only the first one is flagged.
                    if (!overrunSeen) begin
                        errorNext   = 1'b1;
                        overrunNext = 1'b1;
                    end
                end else begin
                    overrunNext = 1'b0;
                    bitCntNext  = '0;
                    stateNext   = IDLE;
                end
            end

            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    // Output register load is independent of framing; it always takes the
    // pre-edge holdData, so a frame completing on the same edge is not seen.
    always_ff @(posedge serialClock) begin
        if (!resetN) begin
            dacOut  <= '0;
            ctrlOut <= '0;
        end else if (!ldac) begin
            dacOut  <= holdData[DATA_BITS-1:0];
            ctrlOut <= holdData[FRAME_BITS-1:DATA_BITS];
        end
    end

endmodule
